axis_tlp_bar_router: RTL

//  Consumes the de-straddled, one-TLP-per-packet AXI4-Stream from the straddle convertor.

---
 rtl/axis_tlp_pkg.sv | 30 +++
 rtl/axis_tlp_out_slice.sv | 55 +++++
 rtl/axis_tlp_bar_router.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/axis_tlp_pkg.sv
// Shared types and constants for the CQ TLP BAR router.
// Holds the descriptor field positions used for BAR decode, the stream widths,
// the router state type and the packed beat payload carried by the output slot.
package axis_tlp_pkg;

  localparam int unsigned TDATA_W       = 512;
  localparam int unsigned TKEEP_W       = 16;
  localparam int unsigned CQ_BAR_ID_LSB = 112;
  localparam int unsigned CQ_BAR_ID_W   = 3;

  typedef enum logic [1:0] {
    IDLE,
    FWD,
    DROP
  } rt_state_t;

  typedef logic [CQ_BAR_ID_W-1:0] bar_id_t;

  typedef struct packed {
    logic [TDATA_W-1:0] tdata;
    logic [TKEEP_W-1:0] tkeep;
    logic               tlast;
  } axis_beat_t;

  // BAR ID field of the CQ descriptor carried on a packet's first beat.
  function automatic bar_id_t get_bar_id(input logic [TDATA_W-1:0] tdata);
    return tdata[CQ_BAR_ID_LSB +: CQ_BAR_ID_W];
  endfunction

endpackage

// File: rtl/axis_tlp_out_slice.sv
// Single-entry registered output slot with valid/ready and a destination port tag.
// Ports:
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   i_load          capture i_beat/i_user/i_port (caller only loads when the slot
//                   is empty or is draining this cycle)
//   i_ready         ready of the port currently tagged in the slot
//   o_valid         slot holds a beat
//   o_beat, o_user  held payload, stable while o_valid && !i_ready
//   o_port          destination port of the held beat
module axis_tlp_out_slice
  import axis_tlp_pkg::*;
#(
  parameter int unsigned USER_W = 161
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load,
  input  axis_beat_t        i_beat,
  input  logic [USER_W-1:0] i_user,
  input  bar_id_t           i_port,
  input  logic              i_ready,
  output logic              o_valid,
  output axis_beat_t        o_beat,
  output logic [USER_W-1:0] o_user,
  output bar_id_t           o_port
);

  logic              r_valid;
  axis_beat_t        r_beat;
  logic [USER_W-1:0] r_user;
  bar_id_t           r_port;

  // Load has priority: a drain and refill in the same cycle keeps the slot full.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_beat  <= '0;
      r_user  <= '0;
      r_port  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_beat  <= i_beat;
      r_user  <= i_user;
      r_port  <= i_port;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_beat  = r_beat;
  assign o_user  = r_user;
  assign o_port  = r_port;

endmodule

// File: rtl/axis_tlp_bar_router.sv
// CQ TLP BAR router: steers each one-TLP-per-packet AXI4-Stream packet to the
// master port selected by the BAR ID in its first-beat descriptor. Packets whose
// BAR ID has no port are accepted and discarded.
// Ports:
//   ACLK, ARESETN           clock, asynchronous active-low reset
//   S_AXIS_*                slave stream from the straddle convertor
//   M_AXIS_*                NUM_PORTS master streams, port p in slice p
//   stat_drop_cnt           discarded packets (AXIS_TLP_BAR_ROUTER_STATS_EN only)
//   stat_pkt_cnt            forwarded packets (AXIS_TLP_BAR_ROUTER_STATS_EN only)
// Optional feature macro: AXIS_TLP_BAR_ROUTER_STATS_EN
module axis_tlp_bar_router
  import axis_tlp_pkg::*;
#(
  parameter int unsigned AXI_TUSER_L = 161,
  parameter int unsigned NUM_PORTS   = 4
) (
  input  logic                             ACLK,
  input  logic                             ARESETN,
  input  logic [AXI_TUSER_L-1:0]           S_AXIS_TUSER,
  input  logic [TDATA_W-1:0]               S_AXIS_TDATA,
  input  logic [TKEEP_W-1:0]               S_AXIS_TKEEP,
  input  logic                             S_AXIS_TLAST,
  input  logic                             S_AXIS_TVALID,
  output logic                             S_AXIS_TREADY,
  output logic [NUM_PORTS*AXI_TUSER_L-1:0] M_AXIS_TUSER,
  output logic [NUM_PORTS*TDATA_W-1:0]     M_AXIS_TDATA,
  output logic [NUM_PORTS*TKEEP_W-1:0]     M_AXIS_TKEEP,
  output logic [NUM_PORTS-1:0]             M_AXIS_TLAST,
  output logic [NUM_PORTS-1:0]             M_AXIS_TVALID,
  input  logic [NUM_PORTS-1:0]             M_AXIS_TREADY
`ifdef AXIS_TLP_BAR_ROUTER_STATS_EN
  ,
  output logic [31:0]                      stat_drop_cnt,
  output logic [31:0]                      stat_pkt_cnt
`endif
);

  rt_state_t              r_state;
  bar_id_t                r_lock_port;

  bar_id_t                w_bar;
  logic                   w_bar_ok;
  logic                   w_sel_ready;
  logic                   w_accept;
  logic                   w_fwd;
  bar_id_t                w_port;
  axis_beat_t             w_in_beat;
  logic                   w_slot_valid;
  axis_beat_t             w_slot_beat;
  logic [AXI_TUSER_L-1:0] w_slot_user;
  bar_id_t                w_slot_port;

  // Descriptor decode; only meaningful on a first beat (IDLE).
  assign w_bar    = get_bar_id(S_AXIS_TDATA);
  assign w_bar_ok = 32'(w_bar) < NUM_PORTS;

  // Ready of the port the slot is currently presenting to.
  always_comb begin
    w_sel_ready = 1'b0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (w_slot_port == CQ_BAR_ID_W'(p)) w_sel_ready = M_AXIS_TREADY[p];
    end
  end

  // Dropped beats never touch the slot, so DROP always accepts.
  assign S_AXIS_TREADY = ARESETN &&
                         ((r_state == DROP) || !w_slot_valid || w_sel_ready);
  assign w_accept      = S_AXIS_TVALID && S_AXIS_TREADY;
  assign w_fwd         = w_accept &&
                         (((r_state == IDLE) && w_bar_ok) || (r_state == FWD));
  assign w_port        = (r_state == IDLE) ? w_bar : r_lock_port;

  assign w_in_beat.tdata = S_AXIS_TDATA;
  assign w_in_beat.tkeep = S_AXIS_TKEEP;
  assign w_in_beat.tlast = S_AXIS_TLAST;

  // Packet framing FSM; the port lock only changes on a first beat.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state     <= IDLE;
      r_lock_port <= '0;
    end else if (w_accept) begin
      case (r_state)
        IDLE: begin
          if (w_bar_ok) begin
            r_lock_port <= w_bar;
            r_state     <= S_AXIS_TLAST ? IDLE : FWD;
          end else begin
            r_state     <= S_AXIS_TLAST ? IDLE : DROP;
          end
        end
        FWD:     if (S_AXIS_TLAST) r_state <= IDLE;
        DROP:    if (S_AXIS_TLAST) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  axis_tlp_out_slice #(
    .USER_W (AXI_TUSER_L)
  ) u_slot (
    .i_clk   (ACLK),
    .i_rst_n (ARESETN),
    .i_load  (w_fwd),
    .i_beat  (w_in_beat),
    .i_user  (S_AXIS_TUSER),
    .i_port  (w_port),
    .i_ready (w_sel_ready),
    .o_valid (w_slot_valid),
    .o_beat  (w_slot_beat),
    .o_user  (w_slot_user),
    .o_port  (w_slot_port)
  );

  // Payload is broadcast; only the tagged port sees TVALID.
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    assign M_AXIS_TDATA[p*TDATA_W +: TDATA_W]         = w_slot_beat.tdata;
    assign M_AXIS_TKEEP[p*TKEEP_W +: TKEEP_W]         = w_slot_beat.tkeep;
    assign M_AXIS_TUSER[p*AXI_TUSER_L +: AXI_TUSER_L] = w_slot_user;
    assign M_AXIS_TLAST[p]  = w_slot_beat.tlast;
    assign M_AXIS_TVALID[p] = w_slot_valid && (w_slot_port == CQ_BAR_ID_W'(p));
  end

`ifdef AXIS_TLP_BAR_ROUTER_STATS_EN
  logic        w_drop_first;
  logic        w_pkt_done;
  logic [31:0] r_drop_cnt;
  logic [31:0] r_pkt_cnt;

  assign w_drop_first = w_accept && (r_state == IDLE) && !w_bar_ok;
  assign w_pkt_done   = w_fwd && S_AXIS_TLAST;

  // Saturating packet counters.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_drop_cnt <= '0;
      r_pkt_cnt  <= '0;
    end else begin
      if (w_drop_first && (r_drop_cnt != 32'hFFFF_FFFF)) r_drop_cnt <= r_drop_cnt + 32'd1;
      if (w_pkt_done && (r_pkt_cnt != 32'hFFFF_FFFF))    r_pkt_cnt  <= r_pkt_cnt + 32'd1;
    end
  end

  assign stat_drop_cnt = r_drop_cnt;
  assign stat_pkt_cnt  = r_pkt_cnt;
`endif

endmodule
